// File: rtl/mealy_pkg.sv
// Shared definitions for the 4-state Mealy encoder/decoder pair: state encoding,
// per-state symbol codes and the receive-side decode table.
package mealy_pkg;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_e;

   // Symbol emitted by the encoder in each state for data bit 1 / data bit 0
   localparam logic [1:0] SYM_S0_IN1 = 2'b00;
   localparam logic [1:0] SYM_S0_IN0 = 2'b10;
   localparam logic [1:0] SYM_S1_IN1 = 2'b01;
   localparam logic [1:0] SYM_S1_IN0 = 2'b00;
   localparam logic [1:0] SYM_S2_IN1 = 2'b10;
   localparam logic [1:0] SYM_S2_IN0 = 2'b01;
   localparam logic [1:0] SYM_S3_IN1 = 2'b11;
   localparam logic [1:0] SYM_S3_IN0 = 2'b00;

   typedef struct packed {
      logic   legal;
      logic   bit_val;
      state_e nxt;
   } dec_t;

   // Inverse of the encoder: recovered bit and next state for a symbol seen in state st
   function automatic dec_t decode(input state_e st, input logic [1:0] sym);
      dec_t d;
      d.legal   = 1'b0;
      d.bit_val = 1'b0;
      d.nxt     = st;
      case (st)
         S0: begin
            if (sym == SYM_S0_IN1)      d = '{legal: 1'b1, bit_val: 1'b1, nxt: S1};
            else if (sym == SYM_S0_IN0) d = '{legal: 1'b1, bit_val: 1'b0, nxt: S1};
         end
         S1: begin
            if (sym == SYM_S1_IN1)      d = '{legal: 1'b1, bit_val: 1'b1, nxt: S2};
            else if (sym == SYM_S1_IN0) d = '{legal: 1'b1, bit_val: 1'b0, nxt: S1};
         end
         S2: begin
            if (sym == SYM_S2_IN1)      d = '{legal: 1'b1, bit_val: 1'b1, nxt: S3};
            else if (sym == SYM_S2_IN0) d = '{legal: 1'b1, bit_val: 1'b0, nxt: S1};
         end
         S3: begin
            if (sym == SYM_S3_IN1)      d = '{legal: 1'b1, bit_val: 1'b1, nxt: S2};
            else if (sym == SYM_S3_IN0) d = '{legal: 1'b1, bit_val: 1'b0, nxt: S3};
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mealy_word_packer.sv
// Packs accepted bits LSB-first into WORD_W-bit words; emits a registered word_valid
// pulse on the edge that accepts the last bit of a word.
module mealy_word_packer #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              acc_i,
   input  logic              bit_i,
   input  logic              clear_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);

   localparam int unsigned CNT_W = $clog2(WORD_W);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] part_q, part_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WORD_W-1:0] merged_c;
   logic              wv_q, wv_d;

   // Insert the incoming bit at the current fill position; a full word is handed off
   always_comb begin
      cnt_d            = cnt_q;
      part_d           = part_q;
      word_d           = word_q;
      wv_d             = 1'b0;
      merged_c         = part_q;
      merged_c[cnt_q]  = bit_i;
      if (clear_i) begin
         cnt_d  = '0;
         part_d = '0;
      end else if (acc_i) begin
         if (cnt_q == CNT_W'(WORD_W - 1)) begin
            word_d = merged_c;
            wv_d   = 1'b1;
            cnt_d  = '0;
            part_d = '0;
         end else begin
            part_d = merged_c;
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         part_q <= '0;
         word_q <= '0;
         wv_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         part_q <= part_d;
         word_q <= word_d;
         wv_q   <= wv_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = wv_q;

endmodule

// File: rtl/mealy_decoder.sv
// Receive-side Mealy decoder: tracks encoder state, recovers data bits, packs words and
// counts illegal symbols. Define MEALY_DEC_RESYNC_EN to resynchronise to S0 on error.
module mealy_decoder
   import mealy_pkg::*;
#(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        sym_in,
   input  logic              sym_valid,
   output logic              bit_out,
   output logic              bit_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              sym_err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [1:0]        estados
);

   state_e           state_q;
   logic             bit_q, bit_valid_q, sym_err_q;
   logic [ERR_W-1:0] err_cnt_q;
   dec_t             dec_c;
   logic             acc_c, bad_c, clear_c;

   always_comb begin
      dec_c = decode(state_q, sym_in);
      acc_c = sym_valid & dec_c.legal;
      bad_c = sym_valid & ~dec_c.legal;
   end

`ifdef MEALY_DEC_RESYNC_EN
   assign clear_c = bad_c;
`else
   assign clear_c = 1'b0;
`endif

   // Decode FSM with registered bit/error pulses; illegal symbols never advance state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S0;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         sym_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         bit_valid_q <= 1'b0;
         sym_err_q   <= 1'b0;
         if (acc_c) begin
            state_q     <= dec_c.nxt;
            bit_q       <= dec_c.bit_val;
            bit_valid_q <= 1'b1;
         end else if (bad_c) begin
            sym_err_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
`ifdef MEALY_DEC_RESYNC_EN
            state_q <= S0;
`endif
         end
      end
   end

   mealy_word_packer #(.WORD_W(WORD_W)) u_packer (
      .clk          (clk),
      .reset        (reset),
      .acc_i        (acc_c),
      .bit_i        (dec_c.bit_val),
      .clear_i      (clear_c),
      .word_o       (word_out),
      .word_valid_o (word_valid)
   );

   assign bit_out   = bit_q;
   assign bit_valid = bit_valid_q;
   assign sym_err   = sym_err_q;
   assign err_cnt   = err_cnt_q;
   assign estados   = state_q;

endmodule

// File: tb/tb_mealy_decoder.sv
// Directed self-checking bench for mealy_decoder with hand-computed expectations.
module tb_mealy_decoder;

   logic       clk;
   logic       reset;
   logic [1:0] sym_in;
   logic       sym_valid;
   logic       bit_out, bit_valid, word_valid, sym_err;
   logic [7:0] word_out, err_cnt;
   logic [1:0] estados;

   int n_asrt = 0;
   int n_fail = 0;

   mealy_decoder #(.WORD_W(8), .ERR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .sym_in     (sym_in),
      .sym_valid  (sym_valid),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .sym_err    (sym_err),
      .err_cnt    (err_cnt),
      .estados    (estados)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      sym_valid = 1'b0;
      sym_in    = 2'b00;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
   endtask

   // Drive one symbol for one cycle; outputs for it are visible on return
   task automatic send(input logic [1:0] s);
      sym_in    = s;
      sym_valid = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      sym_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [1:0] seq_a5 [0:7];
   logic [1:0] seq_t1 [0:3];
   logic       exp_b1 [0:3];
   logic [1:0] exp_s1 [0:3];

   initial begin
      seq_a5 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
      seq_t1 = '{2'b00, 2'b01, 2'b01, 2'b01};
      exp_b1 = '{1'b1, 1'b1, 1'b0, 1'b1};
      exp_s1 = '{2'd1, 2'd2, 2'd1, 2'd2};

      // Reset state
      do_reset();
      chk("rst_estados", 32'(estados), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_word", 32'(word_out), 32'd0);
      chk("rst_pulses", {29'd0, bit_valid, word_valid, sym_err}, 32'd0);

      // Test 1: basic decode
      for (int i = 0; i < 4; i++) begin
         send(seq_t1[i]);
         chk("t1_bit", {30'd0, bit_valid, bit_out}, {30'd0, 1'b1, exp_b1[i]});
         chk("t1_state", 32'(estados), 32'(exp_s1[i]));
         chk("t1_err", 32'(sym_err), 32'd0);
      end
      idle(1);
      chk("t1_bv_drop", 32'(bit_valid), 32'd0);

      // Test 2: full word A5
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(seq_a5[i]);
         chk("t2_wv", 32'(word_valid), (i == 7) ? 32'd1 : 32'd0);
      end
      chk("t2_word", 32'(word_out), 32'hA5);
      chk("t2_state", 32'(estados), 32'd2);
      idle(1);
      chk("t2_wv_drop", 32'(word_valid), 32'd0);
      chk("t2_word_hold", 32'(word_out), 32'hA5);

      // Test 3: S3 self-loop
      do_reset();
      send(2'b00); chk("t3_s1", {30'd0, estados}, 32'd1); chk("t3_b1", 32'(bit_out), 32'd1);
      send(2'b01); chk("t3_s2", {30'd0, estados}, 32'd2); chk("t3_b2", 32'(bit_out), 32'd1);
      send(2'b10); chk("t3_s3", {30'd0, estados}, 32'd3); chk("t3_b3", 32'(bit_out), 32'd1);
      for (int i = 0; i < 3; i++) begin
         send(2'b00);
         chk("t3_hold_s3", 32'(estados), 32'd3);
         chk("t3_bit0", {30'd0, bit_valid, bit_out}, 32'b10);
      end
      idle(1);

      // Test 4: illegal symbol in S3 with bit_cnt=3
      do_reset();
      send(2'b00); send(2'b01); send(2'b10);
      send(2'b01);
      chk("t4_err", 32'(sym_err), 32'd1);
      chk("t4_bv", 32'(bit_valid), 32'd0);
      chk("t4_cnt", 32'(err_cnt), 32'd1);
`ifdef MEALY_DEC_RESYNC_EN
      chk("t4_state", 32'(estados), 32'd0);
      idle(1);
      chk("t4_err_drop", 32'(sym_err), 32'd0);
      // S0:00->1 S1:00->0 S1:01->1 S2:10->1 S3:00->0 S3:11->1 S2:01->0 S1:00->0 = 8'h2D
      send(2'b00); send(2'b00); send(2'b01); send(2'b10);
      send(2'b00); send(2'b11); send(2'b01);
      chk("t4_no_early_wv", 32'(word_valid), 32'd0);
      send(2'b00);
      chk("t4_wv", 32'(word_valid), 32'd1);
      chk("t4_word", 32'(word_out), 32'h2D);
`else
      chk("t4_state", 32'(estados), 32'd3);
      idle(1);
      chk("t4_err_drop", 32'(sym_err), 32'd0);
      // Bits 1,1,1 then S3:11->1 S2:10->1 S3:00->0 S3:00->0 S3:11->1 = 8'h9F
      send(2'b11); send(2'b10); send(2'b00); send(2'b00);
      chk("t4_no_early_wv", 32'(word_valid), 32'd0);
      send(2'b11);
      chk("t4_wv", 32'(word_valid), 32'd1);
      chk("t4_word", 32'(word_out), 32'h9F);
      chk("t4_state_end", 32'(estados), 32'd2);
`endif

      // Test 6: reset mid-word discards partial and clears error count
      for (int i = 0; i < 4; i++) send(seq_a5[i]);
      do_reset();
      chk("t6_state", 32'(estados), 32'd0);
      chk("t6_err_cnt", 32'(err_cnt), 32'd0);
      chk("t6_word", 32'(word_out), 32'd0);
      for (int i = 0; i < 8; i++) send(seq_a5[i]);
      chk("t6_wv", 32'(word_valid), 32'd1);
      chk("t6_word_after", 32'(word_out), 32'hA5);

      // Test 5: gap of 10 idle cycles mid-word
      do_reset();
      for (int i = 0; i < 4; i++) send(seq_a5[i]);
      idle(10);
      chk("t5_gap_bv", 32'(bit_valid), 32'd0);
      chk("t5_gap_state", 32'(estados), 32'd1);
      for (int i = 4; i < 8; i++) begin
         send(seq_a5[i]);
         chk("t5_wv", 32'(word_valid), (i == 7) ? 32'd1 : 32'd0);
      end
      chk("t5_word", 32'(word_out), 32'hA5);
      idle(1);

      // Test 7: error counter saturation (01 is illegal in S0)
      do_reset();
      for (int i = 0; i < 254; i++) send(2'b01);
      chk("t7_cnt_fe", 32'(err_cnt), 32'hFE);
      send(2'b11);
      chk("t7_cnt_ff", 32'(err_cnt), 32'hFF);
      for (int i = 0; i < 6; i++) send(2'b01);
      chk("t7_cnt_sat", 32'(err_cnt), 32'hFF);
      chk("t7_err_pulse", 32'(sym_err), 32'd1);
      chk("t7_state", 32'(estados), 32'd0);
      idle(1);
      chk("t7_err_drop", 32'(sym_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
